// File: rtl/unsigned_div_pkg.sv
// Shared definitions for the sequential unsigned divider.
//   DIV_DW      : default dividend / quotient width
//   DIV_VW      : default divisor / remainder width
//   div_state_t : controller states
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// BUSY  | one restoring step per clock
// DONE  | result held on the outputs, out_valid high
package unsigned_div_pkg;

    localparam int DIV_DW = 16;
    localparam int DIV_VW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_i     : partial remainder entering the step
//   bit_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor
//   rem_o     : partial remainder leaving the step
//   q_bit_o   : quotient bit produced by the step
// The partial remainder is always strictly below the divisor, so the top bit
// of the (VW+1)-bit R register is constantly zero and is not carried here.
module div_restoring_step #(
    parameter int VW = 8
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] divisor_i,
    output logic [VW-1:0] rem_o,
    output logic          q_bit_o
);

    logic [VW:0] trial;

    always_comb begin
        trial   = {rem_i, bit_i} - {1'b0, divisor_i};
        q_bit_o = ~trial[VW];
        // Borrow means the divisor did not fit: keep the shifted remainder.
        // Its top bit is zero in that case, so dropping it loses nothing.
        rem_o   = trial[VW] ? {rem_i[VW-2:0], bit_i} : trial[VW-1:0];
    end

endmodule

// File: rtl/unsigned_16x8_div_seq.sv
// Sequential unsigned divider, restoring algorithm, one quotient bit per clock.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   in_valid / in_ready   : operand handshake (accept only in IDLE)
//   dividend, divisor     : unsigned operands
//   out_valid / out_ready : result handshake (result held until popped)
//   quotient, remainder   : unsigned result
//   div_by_zero           : result came from a zero divisor
// A zero divisor skips iteration: quotient all ones, remainder = low dividend bits.
module unsigned_16x8_div_seq
    import unsigned_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] q_q,     q_d;
    logic [VW-1:0] r_q,     r_d;
    logic [VW-1:0] dvs_q,   dvs_d;
    logic [DW-1:0] quot_q,  quot_d;
    logic [VW-1:0] rem_q,   rem_d;
    logic          dbz_q,   dbz_d;

    logic [VW-1:0] step_rem;
    logic          step_qbit;

    div_restoring_step #(.VW(VW)) u_step (
        .rem_i     (r_q),
        .bit_i     (q_q[DW-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend[VW-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvs_d   = divisor;
                        q_d     = dividend;
                        r_d     = '0;
                        cnt_d   = '0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                q_d   = {q_q[DW-2:0], step_qbit};
                r_d   = step_rem;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // Register the final step directly into the output holders.
                    quot_d  = {q_q[DW-2:0], step_qbit};
                    rem_d   = step_rem;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
